// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MD_WAIT  = 2'd2,
    MEM_WAIT = 2'd3
  } ctrl_state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h00000013;
  localparam logic [5:0]  MD_TIMEOUT = 6'd63;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] satInc32(input logic [31:0] v);
    return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard check between the ID instruction and a load in EX.
module hazard_detect (
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  output logic       load_use_o
);

  // x0 is hardwired to zero, so a load into it can never create a hazard.
  assign load_use_o = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                      ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                       (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control FSM: load-use stalls, redirects, mul/div waits and memory freezes.
module pipeline_ctrl
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  input  logic        ex_md_start,
  input  logic        md_done,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        ex_hold,
  output logic        md_timeout,
  output logic [31:0] stall_cnt
);

  ctrl_state_e state_q, state_d;
  ctrl_state_e retState_q, retState_d;
  logic [5:0]  waitCnt_q, waitCnt_d;
  logic        mdTimeout_q, mdTimeout_d;
  logic [31:0] stallCnt_q;
  logic        loadUse;

  hazard_detect uHazard (
    .ex_mem_read_i (ex_mem_read),
    .ex_rd_i       (ex_rd),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_use_rs1_i  (id_use_rs1),
    .id_use_rs2_i  (id_use_rs2),
    .load_use_o    (loadUse)
  );

  always_comb begin
    state_d      = state_q;
    retState_d   = retState_q;
    waitCnt_d    = waitCnt_q;
    mdTimeout_d  = 1'b0;
    pc_write     = 1'b1;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_busy) begin
          pc_write   = 1'b0;
          ex_hold    = 1'b1;
          state_d    = MEM_WAIT;
          retState_d = RUN;
        end else if (ex_redirect) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (ex_md_start) begin
          pc_write  = 1'b0;
          state_d   = MD_WAIT;
          waitCnt_d = 6'd0;
        end else if (loadUse) begin
          pc_write     = 1'b0;
          id_ex_bubble = 1'b1;
          state_d      = LU_STALL;
        end
      end
      LU_STALL: begin
        if (mem_busy) begin
          pc_write   = 1'b0;
          ex_hold    = 1'b1;
          state_d    = MEM_WAIT;
          retState_d = LU_STALL;
        end else begin
          state_d = RUN;
        end
      end
      MD_WAIT: begin
        pc_write = 1'b0;
        ex_hold  = 1'b1;
        // A memory freeze parks the wait with its count intact; md_done beats the limit.
        if (mem_busy) begin
          state_d    = MEM_WAIT;
          retState_d = MD_WAIT;
        end else if (md_done) begin
          state_d = RUN;
        end else if (waitCnt_q == MD_TIMEOUT) begin
          state_d     = RUN;
          mdTimeout_d = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 6'd1;
        end
      end
      MEM_WAIT: begin
        pc_write = 1'b0;
        ex_hold  = 1'b1;
        if (!mem_busy) begin
          state_d = retState_q;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (reset) begin
      pc_write     = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_hold      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      retState_q  <= RUN;
      waitCnt_q   <= 6'd0;
      mdTimeout_q <= 1'b0;
      stallCnt_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      retState_q  <= retState_d;
      waitCnt_q   <= waitCnt_d;
      mdTimeout_q <= mdTimeout_d;
      stallCnt_q  <= pc_write ? stallCnt_q : satInc32(stallCnt_q);
    end
  end

  assign md_timeout = mdTimeout_q;
  assign stall_cnt  = stallCnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl: cycle table plus multi-cycle mul/div sequences.
module tb_pipeline_ctrl;

  // Input flag packing: {reset, mem_busy, ex_redirect, ex_md_start, md_done, ex_mem_read}
  localparam logic [5:0] F_IDLE  = 6'b000000;
  localparam logic [5:0] F_RST   = 6'b100000;
  localparam logic [5:0] F_BUSY  = 6'b010000;
  localparam logic [5:0] F_REDIR = 6'b001000;
  localparam logic [5:0] F_MDS   = 6'b000100;
  localparam logic [5:0] F_DONE  = 6'b000010;
  localparam logic [5:0] F_LOAD  = 6'b000001;

  // Output packing: {pc_write, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, md_timeout}
  localparam logic [5:0] C_RUN   = 6'b100000;
  localparam logic [5:0] C_HOLD  = 6'b000010;
  localparam logic [5:0] C_RST   = 6'b001100;
  localparam logic [5:0] C_LU    = 6'b000100;
  localparam logic [5:0] C_FLUSH = 6'b101100;
  localparam logic [5:0] C_MDS   = 6'b000000;
  localparam logic [5:0] C_TO    = 6'b100001;

  typedef struct {
    logic [5:0]  flags;
    logic [4:0]  exRd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [1:0]  uses;
    logic [5:0]  expCtl;
    logic [31:0] expCnt;
  } vec_t;

  localparam int NV = 25;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
  logic        ex_md_start, md_done, mem_busy;
  logic        pc_write, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, md_timeout;
  logic [31:0] stall_cnt;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_redirect  (ex_redirect),
    .ex_md_start  (ex_md_start),
    .md_done      (md_done),
    .mem_busy     (mem_busy),
    .pc_write     (pc_write),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .ex_hold      (ex_hold),
    .md_timeout   (md_timeout),
    .stall_cnt    (stall_cnt)
  );

  function automatic vec_t mkVec(input logic [5:0] flags, input logic [4:0] exRd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [1:0] uses, input logic [5:0] expCtl,
                                 input logic [31:0] expCnt);
    vec_t v;
    v.flags  = flags;
    v.exRd   = exRd;
    v.rs1    = rs1;
    v.rs2    = rs2;
    v.uses   = uses;
    v.expCtl = expCtl;
    v.expCnt = expCnt;
    return v;
  endfunction

  // Drive one cycle's inputs just after the falling edge, then let logic settle.
  task automatic applyStimulus(input logic [5:0] flags, input logic [4:0] exRd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [1:0] uses);
    @(negedge clk);
    {reset, mem_busy, ex_redirect, ex_md_start, md_done, ex_mem_read} = flags;
    ex_rd  = exRd;
    id_rs1 = rs1;
    id_rs2 = rs2;
    {id_use_rs1, id_use_rs2} = uses;
    #1;
  endtask

  task automatic drive(input logic [5:0] flags);
    applyStimulus(flags, 5'd0, 5'd0, 5'd0, 2'b00);
  endtask

  task automatic checkCtl(input string tag, input logic [5:0] expCtl);
    logic [5:0] act;
    act = {pc_write, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, md_timeout};
    total++;
    if (act !== expCtl) begin
      bad++;
      $display("[TB] FAIL %s ctl{pc,stall,flush,bubble,hold,to} got=%b want=%b at %0t",
               tag, act, expCtl, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] expCtl,
                             input logic [31:0] expCnt);
    checkCtl(tag, expCtl);
    total++;
    if (stall_cnt !== expCnt) begin
      bad++;
      $display("[TB] FAIL %s stall_cnt got=%0d want=%0d at %0t", tag, stall_cnt, expCnt, $time);
    end
  endtask

  initial begin
    {reset, mem_busy, ex_redirect, ex_md_start, md_done, ex_mem_read} = F_RST;
    ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;

    vecs[0]  = mkVec(F_RST,          5'd0, 5'd0, 5'd0, 2'b00, C_RST,   32'd0);
    vecs[1]  = mkVec(F_IDLE,         5'd0, 5'd0, 5'd0, 2'b00, C_RUN,   32'd0);
    vecs[2]  = mkVec(F_LOAD,         5'd5, 5'd5, 5'd0, 2'b10, C_LU,    32'd0);
    vecs[3]  = mkVec(F_IDLE,         5'd0, 5'd0, 5'd0, 2'b00, C_RUN,   32'd1);
    vecs[4]  = mkVec(F_IDLE,         5'd0, 5'd0, 5'd0, 2'b00, C_RUN,   32'd1);
    vecs[5]  = mkVec(F_LOAD,         5'd0, 5'd0, 5'd0, 2'b10, C_RUN,   32'd1);
    vecs[6]  = mkVec(F_LOAD,         5'd7, 5'd7, 5'd7, 2'b01, C_LU,    32'd1);
    vecs[7]  = mkVec(F_LOAD,         5'd7, 5'd7, 5'd7, 2'b01, C_RUN,   32'd2);
    vecs[8]  = mkVec(F_LOAD,         5'd7, 5'd7, 5'd7, 2'b01, C_LU,    32'd2);
    vecs[9]  = mkVec(F_IDLE,         5'd0, 5'd0, 5'd0, 2'b00, C_RUN,   32'd3);
    vecs[10] = mkVec(F_LOAD,         5'd7, 5'd7, 5'd7, 2'b00, C_RUN,   32'd3);
    vecs[11] = mkVec(F_REDIR|F_LOAD, 5'd5, 5'd5, 5'd0, 2'b10, C_FLUSH, 32'd3);
    vecs[12] = mkVec(F_IDLE,         5'd0, 5'd0, 5'd0, 2'b00, C_RUN,   32'd3);
    vecs[13] = mkVec(F_IDLE,         5'd5, 5'd5, 5'd0, 2'b10, C_RUN,   32'd3);
    vecs[14] = mkVec(F_BUSY|F_REDIR, 5'd0, 5'd0, 5'd0, 2'b00, C_HOLD,  32'd3);
    vecs[15] = mkVec(F_BUSY,         5'd0, 5'd0, 5'd0, 2'b00, C_HOLD,  32'd4);
    vecs[16] = mkVec(F_IDLE,         5'd0, 5'd0, 5'd0, 2'b00, C_HOLD,  32'd5);
    vecs[17] = mkVec(F_IDLE,         5'd0, 5'd0, 5'd0, 2'b00, C_RUN,   32'd6);
    vecs[18] = mkVec(F_RST|F_BUSY,   5'd0, 5'd0, 5'd0, 2'b00, C_RST,   32'd6);
    vecs[19] = mkVec(F_IDLE,         5'd0, 5'd0, 5'd0, 2'b00, C_RUN,   32'd0);
    vecs[20] = mkVec(F_LOAD,         5'd5, 5'd5, 5'd0, 2'b10, C_LU,    32'd0);
    vecs[21] = mkVec(F_BUSY,         5'd0, 5'd0, 5'd0, 2'b00, C_HOLD,  32'd1);
    vecs[22] = mkVec(F_IDLE,         5'd0, 5'd0, 5'd0, 2'b00, C_HOLD,  32'd2);
    vecs[23] = mkVec(F_IDLE,         5'd0, 5'd0, 5'd0, 2'b00, C_RUN,   32'd3);
    vecs[24] = mkVec(F_IDLE,         5'd0, 5'd0, 5'd0, 2'b00, C_RUN,   32'd3);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].flags, vecs[i].exRd, vecs[i].rs1, vecs[i].rs2, vecs[i].uses);
      checkOutput($sformatf("vec%0d", i), vecs[i].expCtl, vecs[i].expCnt);
    end

    // Mul/div finishing on its 10th wait cycle.
    drive(F_RST);
    checkCtl("mdA reset", C_RST);
    drive(F_MDS);
    checkOutput("mdA start", C_MDS, 32'd0);
    for (int k = 0; k < 10; k++) begin
      drive((k == 9) ? F_DONE : F_IDLE);
      checkCtl("mdA hold", C_HOLD);
    end
    drive(F_IDLE);
    checkOutput("mdA back to run", C_RUN, 32'd11);

    // Mul/div that never finishes: 64 wait cycles (count 0..63) then a timeout pulse.
    drive(F_RST);
    checkCtl("mdB reset", C_RST);
    drive(F_MDS);
    checkOutput("mdB start", C_MDS, 32'd0);
    for (int k = 0; k < 64; k++) begin
      drive(F_IDLE);
      checkCtl("mdB hold", C_HOLD);
    end
    drive(F_IDLE);
    checkOutput("mdB timeout pulse", C_TO, 32'd65);
    drive(F_IDLE);
    checkCtl("mdB pulse single", C_RUN);

    // md_done on the final count value beats the timeout.
    drive(F_RST);
    checkCtl("mdC reset", C_RST);
    drive(F_MDS);
    checkCtl("mdC start", C_MDS);
    for (int k = 0; k < 64; k++) begin
      drive((k == 63) ? F_DONE : F_IDLE);
      checkCtl("mdC hold", C_HOLD);
    end
    drive(F_IDLE);
    checkCtl("mdC done wins", C_RUN);

    // Reset part-way through a wait abandons it without a pulse.
    drive(F_RST);
    checkCtl("mdD reset", C_RST);
    drive(F_MDS);
    checkCtl("mdD start", C_MDS);
    for (int k = 0; k < 30; k++) begin
      drive(F_IDLE);
      checkCtl("mdD hold", C_HOLD);
    end
    drive(F_RST);
    checkCtl("mdD mid reset", C_RST);
    drive(F_IDLE);
    checkOutput("mdD after reset", C_RUN, 32'd0);
    for (int k = 0; k < 40; k++) begin
      drive(F_IDLE);
      checkCtl("mdD no pulse", C_RUN);
    end

    // Memory freeze for 3 cycles inside a wait; count resumes from 5.
    drive(F_RST);
    checkCtl("mdE reset", C_RST);
    drive(F_MDS);
    checkCtl("mdE start", C_MDS);
    for (int k = 0; k < 5; k++) begin
      drive(F_IDLE);
      checkCtl("mdE hold pre", C_HOLD);
    end
    for (int k = 0; k < 3; k++) begin
      drive(F_BUSY);
      checkCtl("mdE mem busy", C_HOLD);
    end
    drive(F_IDLE);
    checkCtl("mdE mem exit", C_HOLD);
    for (int k = 0; k < 59; k++) begin
      drive(F_IDLE);
      checkCtl("mdE hold post", C_HOLD);
    end
    drive(F_IDLE);
    checkOutput("mdE timeout pulse", C_TO, 32'd69);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (posedge), reset (synchronous, active-high).
REQ-002 clk  in  1  pipeline clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 id_rs1, id_rs2  in  5 each  source registers of instruction in ID.
REQ-005 id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1/rs2.
REQ-006 ex_rd  in  5  destination of instruction in EX; ex_mem_read  in  1  EX is a load.
REQ-007 ex_redirect  in  1  EX resolved taken branch/jump (PC mispredict).
REQ-008 ex_md_start  in  1  EX issues multi-cycle mul/div; md_done  in  1  mul/div result valid.
REQ-009 mem_busy  in  1  data memory not ready; whole pipeline must freeze.
REQ-010 pc_write  out  1  PC register update enable.
REQ-011 if_id_stall  out  1  drives IF/ID stall (ID receives NOP 32'h00000013, PC_out held).
REQ-012 if_id_flush  out  1  drives IF/ID flush; id_ex_bubble  out  1  ID/EX loads NOP.
REQ-013 ex_hold  out  1  EX/MEM and later stages hold contents.
REQ-014 md_timeout  out  1  one-cycle pulse, mul/div wait exceeded limit.
REQ-015 stall_cnt  out  32  count of cycles with pc_write=0, saturating at 32'hFFFFFFFF.

Function
REQ-016 FSM states SHALL be RUN, LU_STALL, MD_WAIT, MEM_WAIT; registered state, Moore outputs except redirect.
REQ-017 Load-use hazard SHALL be: ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
REQ-018 RUN, no event: pc_write=1, all other control outputs 0.
REQ-019 Priority in RUN SHALL be: mem_busy > ex_redirect > ex_md_start > load-use.
REQ-020 RUN + mem_busy: next MEM_WAIT; same cycle pc_write=0, if_id_stall=0, ex_hold=1.
REQ-021 MEM_WAIT: pc_write=0, ex_hold=1, id_ex_bubble=0; exit to RUN in the cycle after mem_busy falls.
REQ-022 ex_redirect in RUN: same cycle if_id_flush=1, id_ex_bubble=1, pc_write=1; state stays RUN; overrides load-use.
REQ-023 RUN + ex_md_start: next MD_WAIT; MD_WAIT drives pc_write=0, if_id_stall=0, ex_hold=1.
REQ-024 MD_WAIT: 6-bit wait counter cleared on entry, increments each cycle; md_done -> RUN next cycle.
REQ-025 MD_WAIT counter reaching 63 without md_done SHALL pulse md_timeout one cycle and return to RUN.
REQ-026 md_done and counter==63 in same cycle: md_done wins, no md_timeout.
REQ-027 RUN + load-use: pc_write=0, id_ex_bubble=1 that cycle; next LU_STALL for exactly one cycle.
REQ-028 LU_STALL: pc_write=1, no bubble; returns to RUN unconditionally; load-use rechecked in RUN.
REQ-029 mem_busy asserted in MD_WAIT or LU_STALL SHALL take MEM_WAIT, saving return state (MD_WAIT resumes, wait counter frozen).
REQ-030 stall_cnt increments every cycle pc_write=0, holds at all-ones.

Reset
REQ-031 reset SHALL force state=RUN, wait counter=0, stall_cnt=0, md_timeout=0.
REQ-032 During reset cycle outputs SHALL be: pc_write=0, if_id_flush=1, id_ex_bubble=1, if_id_stall=0, ex_hold=0.
REQ-033 Reset mid-MD_WAIT/MEM_WAIT SHALL abandon the wait; no timeout pulse.

Structure
REQ-034 Shared package pipe_pkg SHALL hold state enum, NOP constant 32'h00000013, MD_TIMEOUT=63.
REQ-035 Combinational load-use compare SHALL be sub-module hazard_detect; FSM, counters in pipeline_ctrl.

Verification
REQ-036 ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle pc_write=0, id_ex_bubble=1, then LU_STALL, RUN; stall_cnt=1.
REQ-037 Same but ex_rd=0 -> no stall, pc_write stays 1.
REQ-038 ex_redirect with simultaneous load-use -> if_id_flush=1, id_ex_bubble=1, pc_write=1, no LU_STALL.
REQ-039 ex_md_start, md_done after 10 cycles -> ex_hold=1 for 10 cycles, RUN next, stall_cnt=11.
REQ-040 ex_md_start, no md_done -> md_timeout pulse after 63 waits, RUN next; reset at cycle 30 of repeat -> RUN, no pulse.
REQ-041 mem_busy 3 cycles inside MD_WAIT -> MEM_WAIT, counter frozen, resumes MD_WAIT with prior count.
